// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the IF/LS memory arbiter: default widths and limits,
//   FSM state encoding, requester (owner) IDs and a state-to-owner helper.
//   No ports; imported by mem_arbiter and arb_watchdog.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned DEF_TIMEOUT    = 16;

    // STARVE_MAX is at most 15, TIMEOUT at most 255.
    localparam int unsigned STARVE_CNT_W = 4;
    localparam int unsigned WD_CNT_W     = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_LS   = 2'd2
    } owner_e;

    // The busy state already names the requester that owns the bus.
    function automatic owner_e owner_of(input arb_state_e st);
        case (st)
            ARB_BUSY_IF: return OWNER_IF;
            ARB_BUSY_LS: return OWNER_LS;
            default:     return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog
//   Access watchdog: a down counter loaded on every grant and decremented while
//   an access is outstanding. expire is high in the busy cycle that is TIMEOUT
//   cycles after the grant (counter reached zero).
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   load    in   grant this cycle; reload the counter
//   busy    in   an access is outstanding
//   expire  out  timeout point reached for the outstanding access
module arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic busy,
    output logic expire
);

    logic [WD_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            // First busy cycle sees TIMEOUT-1, so zero lands TIMEOUT cycles after grant.
            cnt_d = WD_CNT_W'(TIMEOUT - 1);
        end else if (busy && (cnt_q != '0)) begin
            cnt_d = cnt_q - WD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = busy & (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single-port memory bus between instruction fetch (IF) and
//   load/store (LS). One access outstanding at a time; LS has priority, IF wins
//   once after STARVE_MAX consecutive lost arbitrations. A watchdog ends an
//   access with an error response if memory does not answer within TIMEOUT.
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   if_req_i/if_addr_i            IF read request, held until if_gnt_o
//   if_gnt_o/if_rvalid_o/if_rdata_o   IF grant, response strobe and data
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_be_i   LS request, held until ls_gnt_o
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o   LS grant, response strobe, data (0 on writes)
//   err_o                         marks the concurrent rvalid as a timeout
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o   memory access, 1 cycle
//   mem_rvalid_i/mem_rdata_i      memory response
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [ADDR_W-1:0]     ls_addr_i,
    input  logic [DATA_W-1:0]     ls_wdata_i,
    input  logic [DATA_W/8-1:0]   ls_be_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_W-1:0]     ls_rdata_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    arb_state_e              state_q, state_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    ls_we_q, ls_we_d;

    owner_e owner;
    logic   busy;
    logic   done;
    logic   timeout;
    logic   grant_point;
    logic   starve_hit;
    logic   ls_win;
    logic   if_win;
    logic   grant;
    logic   wd_expire;

    assign owner   = owner_of(state_q);
    assign busy    = (state_q != ARB_IDLE);
    assign done    = busy & mem_rvalid_i;
    // A response arriving on the last allowed cycle still wins over the timeout.
    assign timeout = busy & wd_expire & ~mem_rvalid_i;

    // rst is active-low; holding it low suppresses grants so all outputs stay 0.
    assign grant_point = rst & (~busy | done);
    assign starve_hit  = if_req_i & (starve_q == STARVE_CNT_W'(STARVE_MAX));
    assign ls_win      = grant_point & ls_req_i & ~starve_hit;
    assign if_win      = grant_point & if_req_i & ~ls_win;
    assign grant       = ls_win | if_win;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (grant),
        .busy   (busy),
        .expire (wd_expire)
    );

    // Next state and bookkeeping.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ls_we_d  = ls_we_q;

        if (timeout) begin
            state_d = ARB_IDLE;
        end else if (ls_win) begin
            state_d = ARB_BUSY_LS;
        end else if (if_win) begin
            state_d = ARB_BUSY_IF;
        end else if (done) begin
            state_d = ARB_IDLE;
        end

        if (ls_win) begin
            ls_we_d = ls_we_i;
        end

        // Only arbitration points count as losses for IF.
        if (if_win) begin
            starve_d = '0;
        end else if (grant_point && if_req_i &&
                     (starve_q != STARVE_CNT_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
            ls_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ls_we_q  <= ls_we_d;
        end
    end

    // Grant-side outputs are driven straight from the winner's request fields.
    always_comb begin
        if_gnt_o    = if_win;
        ls_gnt_o    = ls_win;
        mem_req_o   = grant;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;

        if (ls_win) begin
            mem_we_o    = ls_we_i;
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
            mem_be_o    = ls_be_i;
        end else if (if_win) begin
            mem_addr_o  = if_addr_i;
            mem_be_o    = '1;
        end
    end

    // Response-side outputs are routed to the current owner.
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = '0;
        err_o       = timeout;

        case (owner)
            OWNER_IF: begin
                if_rvalid_o = done | timeout;
                if_rdata_o  = done ? mem_rdata_i : '0;
            end
            OWNER_LS: begin
                ls_rvalid_o = done | timeout;
                ls_rdata_o  = (done && !ls_we_q) ? mem_rdata_i : '0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed scenarios followed by random
//   traffic, every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i = 1'b0;
    logic        ls_we_i = 1'b0;
    logic [31:0] ls_addr_i = '0;
    logic [31:0] ls_wdata_i = '0;
    logic [3:0]  ls_be_i = '0;
    logic        ls_gnt_o, ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        err_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_be_i      (ls_be_i),
        .ls_gnt_o     (ls_gnt_o),
        .ls_rvalid_o  (ls_rvalid_o),
        .ls_rdata_o   (ls_rdata_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Reference model: who owns the bus, how long it has waited, IF losses.
    int unsigned m_owner = 0;   // 0 none, 1 IF, 2 LS
    int unsigned m_age   = 0;   // cycles since grant
    int unsigned m_lost  = 0;   // consecutive IF losses
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic        last_if_gnt = 1'b0;
    logic        last_ls_gnt = 1'b0;

    // Memory responder.
    int          cyc = 0;
    logic        mem_pend = 1'b0;
    int          mem_due = 0;
    logic [31:0] mem_addr_l = '0;
    int          mem_lat = 1;
    logic        lat_rand = 1'b0;

    // DUT outputs captured at the last sample point.
    logic        s_if_gnt, s_ls_gnt, s_if_rv, s_ls_rv, s_err, s_mem_we;
    logic [3:0]  s_mem_be;
    logic [31:0] s_ls_rd;
    logic [63:0] s_quiet;
    int          gnt_log[$];

    task automatic step();
        logic        done, tmo, gp, lw, iw, e_we, e_if_rv, e_ls_rv;
        logic [31:0] e_addr, e_wdata, e_if_rd, e_ls_rd;
        logic [3:0]  e_be;
        int          lat;

        mem_rvalid_i = mem_pend && (cyc == mem_due);
        mem_rdata_i  = mem_rvalid_i ? mem_word(mem_addr_l) : 32'h0BAD_F00D;
        @(negedge clk);
        if (!rst) begin
            m_owner = 0;
            m_lost  = 0;
        end

        done = rst && (m_owner != 0) && mem_rvalid_i;
        tmo  = rst && (m_owner != 0) && !mem_rvalid_i && (m_age == TIMEOUT - 1);
        gp   = rst && ((m_owner == 0) || done);
        lw   = gp && ls_req_i && !(if_req_i && (m_lost == STARVE_MAX));
        iw   = gp && if_req_i && !lw;

        e_we    = lw && ls_we_i;
        e_addr  = lw ? ls_addr_i : (iw ? if_addr_i : 32'h0);
        e_wdata = lw ? ls_wdata_i : 32'h0;
        e_be    = lw ? ls_be_i : (iw ? 4'hF : 4'h0);
        e_if_rv = (m_owner == 1) && (done || tmo);
        e_ls_rv = (m_owner == 2) && (done || tmo);
        e_if_rd = ((m_owner == 1) && done) ? mem_word(m_addr) : 32'h0;
        e_ls_rd = ((m_owner == 2) && done && !m_we) ? mem_word(m_addr) : 32'h0;

        check("gnt", 64'({if_gnt_o, ls_gnt_o}), 64'({iw, lw}));
        check("rvalid", 64'({if_rvalid_o, ls_rvalid_o}), 64'({e_if_rv, e_ls_rv}));
        check("err", 64'(err_o), 64'(tmo));
        check("if_rdata", 64'(if_rdata_o), 64'(e_if_rd));
        check("ls_rdata", 64'(ls_rdata_o), 64'(e_ls_rd));
        check("mem_ctl", 64'({mem_req_o, mem_we_o, mem_be_o}), 64'({lw | iw, e_we, e_be}));
        check("mem_addr", 64'(mem_addr_o), 64'(e_addr));
        check("mem_wdata", 64'(mem_wdata_o), 64'(e_wdata));

        s_if_gnt = if_gnt_o;
        s_ls_gnt = ls_gnt_o;
        s_if_rv  = if_rvalid_o;
        s_ls_rv  = ls_rvalid_o;
        s_err    = err_o;
        s_mem_we = mem_we_o;
        s_mem_be = mem_be_o;
        s_ls_rd  = ls_rdata_o;
        s_quiet  = 64'({if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, err_o, mem_req_o,
                        mem_we_o, mem_be_o, |mem_addr_o, |mem_wdata_o, |if_rdata_o,
                        |ls_rdata_o});
        if (if_gnt_o) gnt_log.push_back(1);
        else if (ls_gnt_o) gnt_log.push_back(2);

        if (lw || iw) begin
            m_owner = lw ? 2 : 1;
            m_age   = 0;
            m_we    = e_we;
            m_addr  = e_addr;
        end else if (done || tmo) begin
            m_owner = 0;
        end else if (m_owner != 0) begin
            m_age++;
        end
        if (iw) m_lost = 0;
        else if (gp && if_req_i && (m_lost < STARVE_MAX)) m_lost++;
        last_if_gnt = iw;
        last_ls_gnt = lw;

        if (mem_rvalid_i) mem_pend = 1'b0;
        if (mem_req_o) begin
            if (lat_rand) lat = ($urandom_range(0, 49) == 0) ? 20 : int'($urandom_range(1, 5));
            else lat = mem_lat;
            mem_pend   = 1'b1;
            mem_addr_l = mem_addr_o;
            mem_due    = cyc + lat;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int n;
        int cnt;
        int wait_cnt;
        int max_wait;

        // 1: reset, then IF-only reads at 0x0, 0x4, 0x8.
        #1 rst = 1'b0;
        if_req_i = 1'b1;   // held through reset: outputs must stay quiet
        step();
        check("t1_reset_quiet", s_quiet, 64'h0);
        if_req_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        gnt_log.delete();
        if_req_i = 1'b1; if_addr_i = 32'h0;
        step();
        if_addr_i = 32'h4;
        step();
        if_addr_i = 32'h8;
        step();
        if_req_i = 1'b0;
        step();
        step();
        check("t1_if_grants", 64'(gnt_log.size()), 64'd3);

        // 2: IF and LS both requesting back-to-back.
        gnt_log.delete();
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h200; ls_be_i = 4'hF;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        repeat (15) step();
        ls_req_i = 1'b0; if_req_i = 1'b0;
        step();
        step();
        check("t2_grant_count", 64'(gnt_log.size()), 64'd15);
        for (int k = 0; k < 15; k++) begin
            if (k < gnt_log.size())
                check("t2_pattern", 64'(gnt_log[k]), ((k % 5) == 4) ? 64'd1 : 64'd2);
        end

        // 3: LS write.
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h100;
        ls_wdata_i = 32'hDEAD_BEEF; ls_be_i = 4'b0011;
        step();
        check("t3_mem_we", 64'(s_mem_we), 64'd1);
        check("t3_mem_be", 64'(s_mem_be), 64'h3);
        ls_req_i = 1'b0; ls_we_i = 1'b0;
        step();
        check("t3_ls_rvalid", 64'(s_ls_rv), 64'd1);
        check("t3_ls_rdata", 64'(s_ls_rd), 64'h0);

        // 4: memory does not answer IF read at 0x20 in time.
        mem_lat = 40;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        step();
        if_req_i = 1'b0;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (s_if_rv && s_err) break;
        end
        check("t4_timeout_cycles", 64'(n), 64'd16);
        cnt = 0;
        repeat (30) begin
            step();
            if (s_if_rv || s_ls_rv || s_err) cnt++;
        end
        check("t4_late_ignored", 64'(cnt), 64'd0);
        mem_lat = 1;

        // 5: reset one cycle after an LS read grant.
        mem_lat = 3;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h300; ls_be_i = 4'hF;
        step();
        check("t5_ls_grant", 64'(s_ls_gnt), 64'd1);
        ls_req_i = 1'b0;
        rst = 1'b0;
        step();
        check("t5_reset_quiet", s_quiet, 64'h0);
        rst = 1'b1;
        cnt = 0;
        repeat (5) begin
            step();
            if (s_ls_rv) cnt++;
        end
        check("t5_no_response", 64'(cnt), 64'd0);
        mem_lat = 1;
        ls_req_i = 1'b1; ls_addr_i = 32'h304;
        step();
        check("t5_regrant", 64'(s_ls_gnt), 64'd1);
        ls_req_i = 1'b0;
        step();
        check("t5_response", 64'(s_ls_rv), 64'd1);

        // 6: random traffic with 1..5 cycle memory (rare slow access).
        lat_rand = 1'b1;
        wait_cnt = 0;
        max_wait = 0;
        repeat (3000) begin
            if (!if_req_i || last_if_gnt) begin
                if_req_i  = ($urandom_range(0, 99) < 45);
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_req_i || last_ls_gnt) begin
                ls_req_i   = ($urandom_range(0, 99) < 55);
                ls_we_i    = 1'($urandom_range(0, 1));
                ls_addr_i  = $urandom & 32'hFFFF_FFFC;
                ls_wdata_i = $urandom;
                ls_be_i    = 4'($urandom_range(1, 15));
            end
            step();
            if (s_if_gnt) wait_cnt = 0;
            else if (if_req_i && s_ls_gnt) wait_cnt++;
            if (wait_cnt > max_wait) max_wait = wait_cnt;
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        repeat (25) step();
        check("t6_if_wait_bound", 64'(max_wait <= int'(STARVE_MAX)), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
